// File: rtl/uart_result_tx_pkg.sv
// Shared definitions for the result UART: request codes, ASCII bytes, FSM encoding
// and the helper that maps (request, row, byte index) to a message byte.
package uart_result_tx_pkg;

    typedef enum logic [1:0] {
        SEND_OFF       = 2'd0,
        SEND_MATCH     = 2'd1,
        SEND_NOT_MATCH = 2'd2
    } send_code_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [7:0] ASCII_M  = 8'h4D;
    localparam logic [7:0] ASCII_N  = 8'h4E;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam logic [2:0] MATCH_LAST_IDX     = 3'd4;
    localparam logic [2:0] NOT_MATCH_LAST_IDX = 3'd1;

    function automatic logic [7:0] hex_ascii(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
    endfunction

    function automatic logic [7:0] msg_byte(input send_code_e code,
                                            input logic [8:0] row,
                                            input logic [2:0] idx);
        logic [7:0] b;
        b = ASCII_LF;
        if (code == SEND_MATCH) begin
            case (idx)
                3'd0:    b = ASCII_M;
                3'd1:    b = hex_ascii({3'b000, row[8]});
                3'd2:    b = hex_ascii(row[7:4]);
                3'd3:    b = hex_ascii(row[3:0]);
                default: b = ASCII_LF;
            endcase
        end else if (idx == 3'd0) begin
            b = ASCII_N;
        end
        return b;
    endfunction

    function automatic logic [2:0] msg_last_idx(input send_code_e code);
        return (code == SEND_MATCH) ? MATCH_LAST_IDX : NOT_MATCH_LAST_IDX;
    endfunction

endpackage

// File: rtl/uart_result_tx_byte.sv
// 8N1 byte serializer. A start accepted in the last stop-bit cycle chains the
// next frame with no idle gap; done flags that last stop-bit cycle.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       done,
    output logic       tx
);

    localparam logic [11:0] LAST_CLK = 12'(CLKS_PER_BIT - 1);

    logic        tx_reg;
    logic        active_reg;
    logic [11:0] clk_cnt_reg;
    logic [3:0]  bit_cnt_reg;
    logic [7:0]  shift_reg;

    assign done = active_reg && (bit_cnt_reg == 4'd9) && (clk_cnt_reg == LAST_CLK);
    assign tx   = tx_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_reg      <= 1'b1;
            active_reg  <= 1'b0;
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
        end else if (start && (!active_reg || done)) begin
            tx_reg      <= 1'b0;
            active_reg  <= 1'b1;
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= data;
        end else if (active_reg) begin
            if (clk_cnt_reg == LAST_CLK) begin
                clk_cnt_reg <= '0;
                if (bit_cnt_reg == 4'd9) begin
                    active_reg  <= 1'b0;
                    tx_reg      <= 1'b1;
                    bit_cnt_reg <= '0;
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                    // bit_cnt 0 is the start bit, so the next data bit index equals bit_cnt
                    tx_reg <= (bit_cnt_reg == 4'd8) ? 1'b1 : shift_reg[bit_cnt_reg[2:0]];
                end
            end else begin
                clk_cnt_reg <= clk_cnt_reg + 12'd1;
            end
        end
    end

endmodule

// File: rtl/uart_result_tx.sv
// Sends "M<row hex>\n" or "N\n" over UART on request; sequences message bytes
// into the byte serializer and reports completion.
module uart_result_tx
    import uart_result_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] UARTsend,
    input  logic [8:0] matchRow,
    output logic       UARTtx,
    output logic       UARTsendComplete,
    output logic       busy
);

    state_e     state_reg;
    send_code_e kind_reg;
    logic [8:0] row_reg;
    logic [2:0] idx_reg;
    logic [7:0] next_byte_reg;
    logic       busy_reg;
    logic       complete_reg;

    logic       req_valid;
    logic       byte_start;
    logic [7:0] byte_data;
    logic       byte_done;
    logic       last_byte;

    assign req_valid = (UARTsend == SEND_MATCH) || (UARTsend == SEND_NOT_MATCH);
    assign last_byte = (idx_reg == msg_last_idx(kind_reg));

    // Byte 0 starts on the capture edge itself, so it comes straight from the request code
    assign byte_start = ((state_reg == S_IDLE) && req_valid) ||
                        ((state_reg == S_SEND) && byte_done && !last_byte);
    assign byte_data  = (state_reg == S_IDLE) ?
                        ((UARTsend == SEND_MATCH) ? ASCII_M : ASCII_N) : next_byte_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            kind_reg      <= SEND_OFF;
            row_reg       <= '0;
            idx_reg       <= '0;
            next_byte_reg <= '0;
            busy_reg      <= 1'b0;
            complete_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    complete_reg <= 1'b0;
                    if (req_valid) begin
                        kind_reg  <= send_code_e'(UARTsend);
                        row_reg   <= matchRow;
                        idx_reg   <= 3'd0;
                        busy_reg  <= 1'b1;
                        state_reg <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Prefetch the byte that follows the one now on the line
                    next_byte_reg <= msg_byte(kind_reg, row_reg, 3'(idx_reg + 3'd1));
                    state_reg     <= S_SEND;
                end
                S_SEND: begin
                    if (byte_done) begin
                        if (last_byte) begin
                            complete_reg <= 1'b1;
                            state_reg    <= S_DONE;
                        end else begin
                            idx_reg   <= idx_reg + 3'd1;
                            state_reg <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    complete_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                    state_reg    <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clock(clock),
        .reset(reset),
        .start(byte_start),
        .data (byte_data),
        .done (byte_done),
        .tx   (UARTtx)
    );

    assign UARTsendComplete = complete_reg;
    assign busy             = busy_reg;

endmodule

// File: tb/tb_uart_result_tx.sv
// Bench for uart_result_tx: per-cycle waveform model of the message timeline,
// a line decoder for literal byte checks, directed cases and random traffic.
module tb_uart_result_tx;

    localparam int CPB = 4;
    localparam int BYTE_CYC = 10 * CPB;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] UARTsend = 2'd0;
    logic [8:0] matchRow = 9'd0;
    logic       UARTtx;
    logic       UARTsendComplete;
    logic       busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // model of the current/last message: first start-bit cycle and its bytes
    bit       m_active = 1'b0;
    int       m_start = 0;
    int       m_n = 0;
    bit [7:0] m_bytes[5];

    // line decoder results
    bit [7:0] rx_q[$];
    int       starts_q[$];
    int       comp_q[$];
    bit       rx_active = 1'b0;
    int       rx_t0 = 0;
    bit [7:0] rx_byte;
    bit [7:0] exp_q[$];

    uart_result_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clock(clock),
        .reset(reset),
        .UARTsend(UARTsend),
        .matchRow(matchRow),
        .UARTtx(UARTtx),
        .UARTsendComplete(UARTsendComplete),
        .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic build_msg(input int code, input int row);
        string hx;
        hx = "0123456789ABCDEF";
        if (code == 1) begin
            m_n = 5;
            m_bytes[0] = 8'h4D;
            m_bytes[1] = hx[(row >> 8) & 1];
            m_bytes[2] = hx[(row >> 4) & 15];
            m_bytes[3] = hx[row & 15];
            m_bytes[4] = 8'h0A;
        end else begin
            m_n = 2;
            m_bytes[0] = 8'h4E;
            m_bytes[1] = 8'h0A;
        end
    endtask

    function automatic logic exp_tx(input int c);
        int o, k, b;
        if (!m_active || c < m_start || c >= m_start + m_n * BYTE_CYC) return 1'b1;
        o = c - m_start;
        k = o / BYTE_CYC;
        b = (o % BYTE_CYC) / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_bytes[k][b-1];
    endfunction

    function automatic logic exp_busy(input int c);
        return m_active && c >= m_start && c <= m_start + m_n * BYTE_CYC;
    endfunction

    function automatic logic exp_comp(input int c);
        return m_active && c == m_start + m_n * BYTE_CYC;
    endfunction

    // compare, then fold this cycle's inputs into the model for the coming edge
    always @(negedge clock) begin
        if (chk_en) begin
            chk("tx", UARTtx, exp_tx(cyc));
            chk("busy", busy, exp_busy(cyc));
            chk("complete", UARTsendComplete, exp_comp(cyc));
        end
        if (reset) begin
            m_active = 1'b0;
        end else if (!exp_busy(cyc) && (UARTsend == 2'd1 || UARTsend == 2'd2)) begin
            m_active = 1'b1;
            m_start = cyc + 1;
            build_msg(int'(UARTsend), int'(matchRow));
        end
    end

    always @(negedge clock) begin
        if (UARTsendComplete === 1'b1) comp_q.push_back(cyc);
        if (reset) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (UARTtx === 1'b0) begin
                rx_active = 1'b1;
                rx_t0 = cyc;
                starts_q.push_back(cyc);
            end
        end else begin
            int o;
            o = cyc - rx_t0;
            if (o % CPB == CPB / 2 && o / CPB >= 1 && o / CPB <= 8)
                rx_byte[o / CPB - 1] = UARTtx;
            if (o == 9 * CPB + CPB / 2) begin
                rx_q.push_back(rx_byte);
                rx_active = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [1:0] code, input logic [8:0] row);
        UARTsend = code;
        matchRow = row;
        tick();
        UARTsend = 2'd0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        @(negedge clock);
        while (UARTsendComplete !== 1'b1 && n < limit) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (n >= limit) begin
            bad++;
            $display("FAIL %s timeout after %0d cycles, no completion pulse", name, limit);
        end
    endtask

    task automatic clear_q();
        rx_q.delete();
        starts_q.delete();
        comp_q.delete();
    endtask

    task automatic check_msg(input string name, input int dur);
        chk({name, "_nbytes"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk({name, "_byte"}, rx_q[i], exp_q[i]);
        chk({name, "_npulse"}, comp_q.size(), 1);
        if (comp_q.size() > 0 && starts_q.size() > 0)
            chk({name, "_dur"}, comp_q[0] - starts_q[0], dur);
        $display("msg %s: bytes=%0d start=%0d", name, rx_q.size(),
                 (starts_q.size() > 0) ? starts_q[0] : -1);
        clear_q();
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk_en = 1'b1;
        chk("rst_tx", UARTtx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_complete", UARTsendComplete, 1'b0);
        reset = 1'b0;
        repeat (3) tick();
        clear_q();

        // MATCH 0x17B
        send(2'd1, 9'h17B);
        wait_done("m17b", 400);
        tick();
        exp_q = '{8'h4D, 8'h31, 8'h37, 8'h42, 8'h0A};
        check_msg("m17b", 200);

        // NOT_MATCH with a random row that must not matter
        send(2'd2, 9'($urandom));
        wait_done("nm", 400);
        tick();
        exp_q = '{8'h4E, 8'h0A};
        check_msg("nm", 80);

        // request while busy ignored; request in first non-busy cycle accepted
        send(2'd1, 9'h17B);
        repeat (30) tick();
        send(2'd1, 9'h000);
        repeat (100) tick();
        send(2'd2, 9'h000);
        wait_done("busy_ign", 400);
        tick();
        exp_q = '{8'h4D, 8'h31, 8'h37, 8'h42, 8'h0A};
        check_msg("busy_ign", 200);
        send(2'd1, 9'h000);
        wait_done("m000", 400);
        tick();
        exp_q = '{8'h4D, 8'h30, 8'h30, 8'h30, 8'h0A};
        check_msg("m000", 200);

        // reset mid-message
        send(2'd1, 9'h155);
        repeat (50) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_tx", UARTtx, 1'b1);
        chk("abort_busy", busy, 1'b0);
        repeat (250) tick();
        chk("abort_npulse", comp_q.size(), 0);
        clear_q();
        send(2'd2, 9'h1FF);
        wait_done("after_rst", 400);
        tick();
        exp_q = '{8'h4E, 8'h0A};
        check_msg("after_rst", 80);

        // request and reset in the same cycle: reset wins
        UARTsend = 2'd1;
        matchRow = 9'h0F0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        UARTsend = 2'd0;
        chk("rst_req_busy", busy, 1'b0);
        repeat (60) tick();
        chk("rst_req_nbytes", starts_q.size(), 0);
        clear_q();

        // code 3 ignored, held code 1 gives one message
        UARTsend = 2'd3;
        repeat (5) tick();
        chk("code3_busy", busy, 1'b0);
        UARTsend = 2'd1;
        matchRow = 9'h0C3;
        repeat (10) tick();
        UARTsend = 2'd0;
        wait_done("held", 400);
        repeat (60) tick();
        exp_q = '{8'h4D, 8'h30, 8'h43, 8'h33, 8'h0A};
        check_msg("held", 200);

        // hex digit boundaries
        send(2'd1, 9'h1FF);
        wait_done("m1ff", 400);
        tick();
        exp_q = '{8'h4D, 8'h31, 8'h46, 8'h46, 8'h0A};
        check_msg("m1ff", 200);
        send(2'd1, 9'h0A0);
        wait_done("m0a0", 400);
        tick();
        exp_q = '{8'h4D, 8'h30, 8'h41, 8'h30, 8'h0A};
        check_msg("m0a0", 200);

        // random traffic against the per-cycle model
        for (int it = 0; it < 40; it++) begin
            int gap;
            int hold;
            gap = $urandom_range(0, 60);
            for (int g = 0; g < gap; g++) begin
                UARTsend = ($urandom_range(0, 3) == 0) ? 2'd3 : 2'd0;
                matchRow = 9'($urandom);
                tick();
            end
            UARTsend = 2'($urandom_range(0, 3));
            matchRow = 9'($urandom);
            if ($urandom_range(0, 9) == 0) reset = 1'b1;
            hold = $urandom_range(1, 12);
            $display("rand %0d: code=%0d row=%03h hold=%0d reset=%0b",
                     it, UARTsend, matchRow, hold, reset);
            for (int h = 0; h < hold; h++) begin
                tick();
                reset = 1'b0;
            end
            UARTsend = 2'd0;
        end
        repeat (250) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_result_tx.md
UART_RESULT_TX -- requirements
Module: uart_result_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit period (valid range 2..4095).
REQ-002 SHALL have port clock  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port UARTsend  input  2  result request code: 0 OFF, 1 MATCH, 2 NOT_MATCH, 3 reserved.
REQ-005 SHALL have port matchRow  input  9  row index reported with a MATCH; sampled with the request.
REQ-006 SHALL have port UARTtx  output  1  serial line, 8N1, LSB first, idle high.
REQ-007 SHALL have port UARTsendComplete  output  1  one-cycle pulse when the last stop bit of a message ends.
REQ-008 SHALL have port busy  output  1  high from the cycle after capture through the completion pulse cycle.

Function
REQ-009 SHALL capture UARTsend and matchRow on a rising edge where busy is low and UARTsend is 1 or 2; UARTsend may be a single-cycle pulse.
REQ-010 SHALL ignore UARTsend while busy is high, and SHALL ignore code 3 and code 0 in all states.
REQ-011 MATCH message SHALL be 5 bytes: 0x4D 'M', then uppercase ASCII hex of matchRow[8], matchRow[7:4], matchRow[3:0], then 0x0A.
REQ-012 NOT_MATCH message SHALL be 2 bytes: 0x4E 'N', then 0x0A.
REQ-013 Hex digits SHALL map 0-9 to 0x30-0x39 and A-F to 0x41-0x46; matchRow[8] yields only '0' or '1'.
REQ-014 Each byte frame SHALL be start bit (0), 8 data bits LSB first, one stop bit (1), each held exactly CLKS_PER_BIT cycles; 10*CLKS_PER_BIT cycles per byte.
REQ-015 Bytes SHALL be sent back-to-back with no idle gap between the stop bit of one byte and the start bit of the next.
REQ-016 With capture on edge T, UARTtx SHALL go low in the cycle after edge T (start bit of byte 0).
REQ-017 UARTsendComplete SHALL be high for exactly one cycle, beginning N*10*CLKS_PER_BIT cycles after UARTtx first went low (N = byte count); UARTtx is high in that cycle.
REQ-018 busy SHALL fall the cycle after the completion pulse; a request present in that later cycle SHALL be captured.
REQ-019 Top FSM states: IDLE, LOAD (select next byte), SEND (byte serializer active), DONE (completion pulse); IDLE->LOAD on valid request, LOAD->SEND, SEND->LOAD while bytes remain, SEND->DONE after last byte, DONE->IDLE unconditionally.
REQ-020 Byte index counter SHALL be 3 bits, reset to 0 on each capture, and SHALL never exceed N-1.
REQ-021 Bit-period counter SHALL be 12 bits and wrap to 0 at CLKS_PER_BIT-1; bit counter 4 bits, 0..9.
REQ-022 UARTtx SHALL be driven from a register (glitch-free).

Reset
REQ-023 On reset: UARTtx=1, UARTsendComplete=0, busy=0, FSM=IDLE, all counters and captured data=0.
REQ-024 Reset asserted mid-message SHALL abort immediately: UARTtx high the next cycle, no UARTsendComplete pulse.
REQ-025 Request and reset in the same cycle: reset wins, request discarded.

Structure
REQ-026 Shared package SHALL hold UARTsend codes (OFF/MATCH/NOT_MATCH), ASCII constants ('M','N',LF), and the FSM state encoding.
REQ-027 SHALL instantiate one sub-module uart_tx_byte (start/byte in, done pulse out, serial out) with CLKS_PER_BIT passed through; uart_result_tx owns message sequencing only.

Verification (CLKS_PER_BIT=4)
REQ-028 MATCH pulse, matchRow=0x17B -> UART bytes 0x4D,0x31,0x37,0x42,0x0A; UARTsendComplete pulse exactly 200 cycles after start bit begins.
REQ-029 NOT_MATCH pulse -> bytes 0x4E,0x0A; completion pulse 80 cycles after start bit; matchRow ignored.
REQ-030 Second MATCH request injected while busy (row 0x000) -> ignored; only first message on line; request one cycle after busy falls -> accepted, "M000\n".
REQ-031 Reset asserted at cycle 50 of a MATCH message -> UARTtx high next cycle, busy=0, no completion pulse; fresh NOT_MATCH afterward sent correctly.
REQ-032 UARTsend=3 and held UARTsend=1 for 10 cycles -> code 3 ignored; held code yields exactly one message.
REQ-033 matchRow=0x1FF and 0x0A0 -> "M1FF\n" and "M0A0\n", checking uppercase hex and digit mapping boundaries.
